// File: rtl/boreal_ledger_arb.sv
// Append-side arbiter/sequencer for the Boreal ledger: round-robin write-port sharing,
// cycle stamping, capacity/seal enforcement and range-checked public reads.
module boreal_ledger_arb #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*192-1:0]  req_event,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 seal,
  output logic                 led_wr,
  output logic [255:0]         led_event,
  output logic [31:0]          led_cycle,
  output logic [10:0]          count,
  output logic                 full,
  output logic                 sealed,
  input  logic                 rd_req_in,
  input  logic [9:0]           rd_addr_in,
  output logic                 led_rd_req,
  output logic [9:0]           led_rd_addr,
  output logic                 rd_valid,
  output logic                 rd_err
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [10:0] DEPTH_C = 11'(DEPTH);

  typedef enum logic {RUN, CLOSED} state_t;

  state_t          r_state;
  logic [LW-1:0]   r_last;
  logic [10:0]     r_issued;
  logic [10:0]     r_count;
  logic [31:0]     r_cyc;
  logic            r_led_wr;
  logic [191:0]    r_led_event;
  logic [31:0]     r_led_cycle;
  logic            r_rd_req;
  logic [9:0]      r_rd_addr;
  logic            r_rd_valid;
  logic            r_rd_err;

  logic [NREQ-1:0] w_grant;
  logic [LW-1:0]   w_idx;
  logic [LW-1:0]   w_win;
  logic            w_found;
  logic            w_hs;
  logic            w_rd_ok;

  // Search starts one past the last winner so every requester is reached within NREQ grants.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    w_grant = '0;
    w_idx   = '0;
    w_win   = r_last;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = LW'((int'(r_last) + k) % NREQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    if (w_found && r_state == RUN && !seal && !rst) w_grant[w_win] = 1'b1;
  end

  assign w_hs    = |(req_valid & w_grant);
  assign w_rd_ok = rd_req_in && ({1'b0, rd_addr_in} < r_count);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_last      <= LW'(NREQ - 1);
      r_issued    <= '0;
      r_count     <= '0;
      r_cyc       <= '0;
      r_led_wr    <= 1'b0;
      r_led_event <= '0;
      r_led_cycle <= '0;
      r_rd_req    <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_cyc    <= r_cyc + 32'd1;
      r_led_wr <= w_hs;
      if (w_hs) begin
        r_led_event <= req_event[192*w_win +: 192];
        r_led_cycle <= r_cyc;
        r_last      <= w_win;
        if (r_issued != DEPTH_C) r_issued <= r_issued + 11'd1;
      end
      if (r_led_wr) r_count <= r_count + 11'd1;

      case (r_state)
        RUN:     if (seal || (w_hs && r_issued == DEPTH_C - 11'd1)) r_state <= CLOSED;
        default: r_state <= CLOSED;
      endcase

      r_rd_req   <= w_rd_ok;
      if (w_rd_ok) r_rd_addr <= rd_addr_in;
      r_rd_valid <= r_rd_req;
      r_rd_err   <= rd_req_in && !w_rd_ok;
    end
  end

  // Reset cancels an append already on its way to the ledger.
  assign led_wr      = r_led_wr & ~rst;
  assign req_ready   = w_grant;
  assign led_event   = {64'h0, r_led_event};
  assign led_cycle   = r_led_cycle;
  assign count       = r_count;
  assign full        = (r_issued == DEPTH_C);
  assign sealed      = (r_state == CLOSED);
  assign led_rd_req  = r_rd_req;
  assign led_rd_addr = r_rd_addr;
  assign rd_valid    = r_rd_valid;
  assign rd_err      = r_rd_err;

endmodule

// File: tb/tb_boreal_ledger_arb.sv
// Bench for boreal_ledger_arb: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of the ledger front end.
module tb_boreal_ledger_arb;

  localparam int NREQ  = 4;
  localparam int DEPTH = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*192-1:0] req_event;
  logic [NREQ-1:0]     req_ready;
  logic                seal;
  logic                led_wr;
  logic [255:0]        led_event;
  logic [31:0]         led_cycle;
  logic [10:0]         count;
  logic                full;
  logic                sealed;
  logic                rd_req_in;
  logic [9:0]          rd_addr_in;
  logic                led_rd_req;
  logic [9:0]          led_rd_addr;
  logic                rd_valid;
  logic                rd_err;

  boreal_ledger_arb #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_event(req_event),
    .req_ready(req_ready), .seal(seal), .led_wr(led_wr), .led_event(led_event),
    .led_cycle(led_cycle), .count(count), .full(full), .sealed(sealed),
    .rd_req_in(rd_req_in), .rd_addr_in(rd_addr_in), .led_rd_req(led_rd_req),
    .led_rd_addr(led_rd_addr), .rd_valid(rd_valid), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int last_grant;

  // Model of what the outputs must show in the current cycle.
  bit           m_closed;
  int           m_issued, m_count, m_last;
  logic [31:0]  m_cyc, m_lcyc;
  logic [191:0] m_ev;
  bit           m_led_wr, m_rdreq, m_rdvalid, m_rderr;
  logic [9:0]   m_rdaddr;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_closed = 0; m_issued = 0; m_count = 0; m_last = NREQ - 1;
    m_cyc = '0; m_lcyc = '0; m_ev = '0; m_led_wr = 0;
    m_rdreq = 0; m_rdvalid = 0; m_rderr = 0; m_rdaddr = '0;
  endtask

  // Called just after a falling edge with inputs already driven; checks, then
  // advances the model across the next rising edge.
  task automatic step();
    int w;
    logic [NREQ-1:0] er;
    int old_count;
    bit ok;
    #1;
    w = -1;
    er = '0;
    if (!rst && !m_closed && !seal)
      for (int k = 1; k <= NREQ; k++) begin
        int i = (m_last + k) % NREQ;
        if (w < 0 && req_valid[i]) w = i;
      end
    if (w >= 0) er[w] = 1'b1;

    check("req_ready",   256'(req_ready),   256'(er));
    check("led_wr",      256'(led_wr),      256'(m_led_wr & ~rst));
    check("led_event",   led_event,         {64'h0, m_ev});
    check("led_cycle",   256'(led_cycle),   256'(m_lcyc));
    check("count",       256'(count),       256'(m_count));
    check("full",        256'(full),        256'(m_issued == DEPTH));
    check("sealed",      256'(sealed),      256'(m_closed));
    check("led_rd_req",  256'(led_rd_req),  256'(m_rdreq));
    check("led_rd_addr", 256'(led_rd_addr), 256'(m_rdaddr));
    check("rd_valid",    256'(rd_valid),    256'(m_rdvalid));
    check("rd_err",      256'(rd_err),      256'(m_rderr));

    last_grant = -1;
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) last_grant = i;

    if (rst) model_reset();
    else begin
      old_count = m_count;
      if (m_led_wr) m_count++;
      m_led_wr = (w >= 0);
      if (w >= 0) begin
        m_ev     = req_event[192*w +: 192];
        m_lcyc   = m_cyc;
        m_last   = w;
        m_issued++;
      end
      if (seal || m_issued == DEPTH) m_closed = 1;
      m_cyc++;
      ok = rd_req_in && (int'(rd_addr_in) < old_count);
      m_rdvalid = m_rdreq;
      m_rdreq   = ok;
      if (ok) m_rdaddr = rd_addr_in;
      m_rderr   = rd_req_in && !ok;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = '0; seal = 0; rd_req_in = 0; rd_addr_in = '0;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < NREQ*192/32; i++) req_event[32*i +: 32] = $urandom;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  int pulses;

  initial begin
    rst = 1;
    idle_inputs();
    rand_payload();
    repeat (2) @(negedge clk);
    model_reset();
    step();
    rst = 0;

    // Fairness: all requesters continuously valid from reset.
    do_reset();
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("fair_grant", 256'(last_grant), 256'(k % NREQ));
      check("fair_wr",    256'(led_wr),     256'(1));
      check("fair_cycle", 256'(led_cycle),  256'(k));
      check("fair_event", 256'(led_event[191:0]), 256'(req_event[192*(k%NREQ) +: 192]));
    end
    idle_inputs();
    step(); step();
    check("fair_count",  256'(count),  256'(8));
    check("fair_full",   256'(full),   256'(1));
    check("fair_sealed", 256'(sealed), 256'(1));

    // Capacity: ten requests from one source, only DEPTH may be appended.
    do_reset();
    pulses = 0;
    req_valid = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      if (k == 10) req_valid = '0;
      step();
      if (led_wr) pulses++;
    end
    check("cap_pulses", 256'(pulses), 256'(8));
    check("cap_count",  256'(count),  256'(8));
    check("cap_full",   256'(full),   256'(1));
    check("cap_sealed", 256'(sealed), 256'(1));
    req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("cap_noready", 256'(last_grant), 256'(-1));
    end

    // Sparse requests.
    do_reset();
    req_valid = 4'b0100; step();
    check("sparse_g0", 256'(last_grant), 256'(2));
    req_valid = 4'b1010; step();
    check("sparse_g1", 256'(last_grant), 256'(3));
    step();
    check("sparse_g2", 256'(last_grant), 256'(1));
    idle_inputs(); step();

    // Seal collides with a request.
    do_reset();
    req_valid = 4'b0001; seal = 1; step();
    check("seal_nogrant", 256'(last_grant), 256'(-1));
    seal = 0; req_valid = '1; step();
    check("seal_nowr",  256'(led_wr), 256'(0));
    check("seal_flag",  256'(sealed), 256'(1));
    for (int k = 0; k < 4; k++) step();
    check("seal_sticky", 256'(sealed), 256'(1));
    check("seal_count",  256'(count),  256'(0));

    // Reads against count=3.
    do_reset();
    req_valid = 4'b0001;
    repeat (3) step();
    idle_inputs(); step();
    check("rd_count3", 256'(count), 256'(3));
    rd_req_in = 1; rd_addr_in = 10'd2; step();
    rd_req_in = 0;
    check("rd_ok_req",  256'(led_rd_req),  256'(1));
    check("rd_ok_addr", 256'(led_rd_addr), 256'(2));
    check("rd_ok_err",  256'(rd_err),      256'(0));
    rd_req_in = 1; rd_addr_in = 10'd3; step();
    rd_req_in = 0;
    check("rd_ok_valid", 256'(rd_valid),   256'(1));
    check("rd_bad_err",  256'(rd_err),     256'(1));
    check("rd_bad_req",  256'(led_rd_req), 256'(0));
    step();
    check("rd_bad_novalid", 256'(rd_valid), 256'(0));

    // Reset in the cycle after a handshake.
    do_reset();
    req_valid = 4'b0010; step();
    check("rstmid_grant", 256'(last_grant), 256'(1));
    req_valid = '0; rst = 1;
    #1 check("rstmid_cancel", 256'(led_wr), 256'(0));
    step();
    rst = 0;
    check("rstmid_count", 256'(count), 256'(0));
    req_valid = '1; step();
    check("rstmid_next", 256'(last_grant), 256'(0));
    check("rstmid_cyc",  256'(led_cycle),  256'(0));
    idle_inputs(); step();

    // Randomized traffic with occasional seal and reset.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        req_valid  = NREQ'($urandom);
        rand_payload();
        seal       = ($urandom_range(0, 39) == 0);
        rd_req_in  = $urandom_range(0, 1) == 1;
        rd_addr_in = 10'($urandom_range(0, 10));
        rst        = ($urandom_range(0, 49) == 0);
        step();
        rst = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boreal_ledger_arb.md
# boreal_ledger_arb

Append-side arbiter and sequencer for the Boreal append-only ledger. Shares the ledger's single write port between NREQ gate-side requesters using round-robin arbitration, and stamps each append with a free-running cycle count. Enforces the append-only guarantee by refusing appends once DEPTH entries exist, or once sealed, so the ledger index never wraps. Also range-checks public reads so only committed entries are fetched.

## Interface
- NREQ, 4, number of append requesters (2..8)
- DEPTH, 1024, ledger capacity in entries; must equal the ledger's DEPTH (power of two, ≤ 1024)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has an event pending
- req_event  in  NREQ*192  event payload, requester i at bits [192*i +: 192]
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- seal  in  1  sticky request to close the ledger
- led_wr  out  1  append strobe to ledger
- led_event  out  256  {64'h0, payload}; ledger overwrites [255:192] with hash
- led_cycle  out  32  cycle stamp of the append
- count  out  11  committed entries (led_wr pulses since reset)
- full  out  1  issued count == DEPTH
- sealed  out  1  no further appends will be granted
- rd_req_in  in  1  public read request
- rd_addr_in  in  10  public read address
- led_rd_req  out  1  forwarded read strobe to ledger
- led_rd_addr  out  10  forwarded read address
- rd_valid  out  1  ledger rd_data valid this cycle
- rd_err  out  1  read rejected (address ≥ count)

## Operation
- States: RUN, CLOSED. Reset → RUN. RUN → CLOSED when seal=1 or issued==DEPTH after a grant. CLOSED is left only by rst.
- issued: 11-bit counter, +1 per handshake, saturates at DEPTH; full = (issued==DEPTH).
- Arbitration in RUN only. Round-robin pointer last (reset NREQ-1): search order last+1, last+2, … mod NREQ. First requester with req_valid=1 gets req_ready=1 (combinational from req_valid, state and last). At most one req_ready high per cycle. last updates to the winner on handshake only.
- seal=1 in a cycle: req_ready forced 0 in that same cycle (seal has priority over any pending grant); sealed=1 from the next cycle.
- Handshake captures {64'h0, req_event[i]} and cyc into output register; led_wr=1 for exactly the next cycle. Without a handshake led_wr=0; led_event/led_cycle hold their last values.
- cyc: 32-bit free-running counter, reset 0, +1 every cycle, wraps 0xFFFFFFFF→0. led_cycle = cyc value in the handshake cycle.
- count: +1 on each led_wr cycle (lags issued by one cycle while an append is in flight).
- Reads: on rd_req_in, if rd_addr_in < count then led_rd_req=1, led_rd_addr=rd_addr_in (registered, next cycle), and rd_valid=1 the cycle after that. Otherwise rd_err=1 for one cycle (next cycle) and no ledger read. Reads are allowed in both states.
- rst mid-operation: an in-flight led_wr is cancelled. All counters, last, and state are reinitialized.

## Timing
- Reset values: req_ready=0 during rst, led_wr=0, led_event=0, led_cycle=0, count=0, full=0, sealed=0, led_rd_req=0, led_rd_addr=0, rd_valid=0, rd_err=0.
- Append latency: handshake in cycle N → led_wr in N+1. Throughput is one append per cycle, back-to-back.
- Read latency: rd_req_in in N → led_rd_req in N+1 → rd_valid in N+2. rd_err in N+1. Fully pipelined.
- full goes to 1 in the cycle after the DEPTH-th handshake; req_ready is already 0 in that cycle.

## Test plan
- Fairness: all 4 req_valid held high from reset for 8 cycles → grants 0,1,2,3,0,1,2,3. led_wr is high on cycles 2–9. led_event[191:0] matches each source's payload.
- Sparse requests: only src 2 valid, then src 1 and src 3 valid together → src 2 granted first, then src 3 before src 1, then src 1.
- Capacity (DEPTH=8): 10 requests → exactly 8 led_wr pulses. Then full=1, sealed=1, count=8, and req_ready stays 0 thereafter.
- Seal collision: seal=1 in the same cycle as req_valid[0]=1 → no grant, no led_wr. sealed=1 the next cycle and stays 1 until rst.
- Reads: with count=3, read addr 2 → led_rd_req at +1, rd_valid at +2. Read addr 3 → rd_err at +1 and no led_rd_req.
- Reset mid-append: rst asserted in the cycle after a handshake → led_wr=0 and count=0. cyc restarts at 0, and the next grant goes to src 0.
